// File: rtl/sample_envelope.sv
// sample_envelope: moving-average amplitude envelope of a signed PCM stream.
// Produces valid/last/index/data in the form the downstream word clipper expects.
// Optional DC-removal front stage: define SAMPLE_ENVELOPE_DC_REMOVE_EN.
// Default build (macro undefined) has a 2-edge latency and no DC logic.
module sample_envelope #(
  parameter int LOG2_WIN = 4,
  parameter int IDX_W    = 32,
  parameter int DC_SHIFT = 8
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             ivalid,
  input  logic             ilast,
  input  logic [15:0]      isample,
  output logic             ovalid,
  output logic             olast,
  output logic [IDX_W-1:0] oidx,
  output logic [15:0]      odata
);

  localparam int WIN   = 1 << LOG2_WIN;
  localparam int SUM_W = 15 + LOG2_WIN;

  // Elaboration-time guard on the configurable parameters.
  if (LOG2_WIN < 1 || LOG2_WIN > 8) begin : g_bad_win
    $error("sample_envelope: LOG2_WIN must be within 1..8");
  end
  if (DC_SHIFT < 1 || DC_SHIFT > 16) begin : g_bad_shift
    $error("sample_envelope: DC_SHIFT must be within 1..16");
  end

  // |x| saturated into 15 bits; the single unrepresentable value -32768 clamps.
  function automatic logic [14:0] abs_sat(input logic [15:0] x);
    logic [15:0] neg;
    neg = ~x + 16'd1;
    if (x == 16'h8000) begin
      abs_sat = 15'h7fff;
    end else if (x[15]) begin
      abs_sat = neg[14:0];
    end else begin
      abs_sat = x[14:0];
    end
  endfunction

  // Clamp a 17-bit signed value into the 16-bit signed range.
  function automatic logic [15:0] sat16(input logic [16:0] v);
    if (v[16] != v[15]) begin
      sat16 = v[16] ? 16'h8000 : 16'h7fff;
    end else begin
      sat16 = v[15:0];
    end
  endfunction

  // Sample stream feeding the magnitude stage.
  logic        s1_in_valid_s;
  logic        s1_in_last_s;
  logic [15:0] s1_in_x_s;

`ifdef SAMPLE_ENVELOPE_DC_REMOVE_EN
  logic signed [16:0] dc_r;
  logic signed [16:0] dc_diff_s;
  logic               s0_valid_r;
  logic               s0_last_r;
  logic [15:0]        s0_x_r;

  // Difference between the incoming sample and the current DC estimate.
  always_comb begin
    dc_diff_s = $signed({isample[15], isample}) - dc_r;
  end

  // Stage 0: subtract the DC estimate and track it; the estimate restarts
  // from zero as soon as the final sample of an utterance is accepted, so the
  // next utterance never sees a stale estimate even when it follows directly.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      dc_r       <= 17'sd0;
      s0_valid_r <= 1'b0;
      s0_last_r  <= 1'b0;
      s0_x_r     <= 16'd0;
    end else if (ivalid) begin
      s0_valid_r <= 1'b1;
      s0_last_r  <= ilast;
      s0_x_r     <= sat16(dc_diff_s);
      if (ilast) begin
        dc_r <= 17'sd0;
      end else begin
        dc_r <= dc_r + (dc_diff_s >>> DC_SHIFT);
      end
    end else begin
      s0_valid_r <= 1'b0;
    end
  end

  assign s1_in_valid_s = s0_valid_r;
  assign s1_in_last_s  = s0_last_r;
  assign s1_in_x_s     = s0_x_r;
`else
  assign s1_in_valid_s = ivalid;
  assign s1_in_last_s  = ilast;
  assign s1_in_x_s     = isample;
`endif

  logic        s1_valid_r;
  logic        s1_last_r;
  logic [14:0] s1_mag_r;

  // Stage 1: register the saturated magnitude of each accepted sample.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_mag_r   <= 15'd0;
    end else if (s1_in_valid_s) begin
      s1_valid_r <= 1'b1;
      s1_last_r  <= s1_in_last_s;
      s1_mag_r   <= abs_sat(s1_in_x_s);
    end else begin
      s1_valid_r <= 1'b0;
    end
  end

  logic [14:0]         hist_r [0:WIN-1];
  logic [LOG2_WIN-1:0] ptr_r;
  logic [SUM_W-1:0]    sum_r;
  logic [IDX_W-1:0]    idx_r;
  logic [14:0]         oldest_s;
  logic [SUM_W-1:0]    sum_next_s;

  // Window sum after replacing the oldest magnitude with the newest one.
  // The sum always contains the oldest entry, so the subtraction never wraps.
  always_comb begin
    oldest_s   = hist_r[ptr_r];
    sum_next_s = sum_r - {{LOG2_WIN{1'b0}}, oldest_s}
                       + {{LOG2_WIN{1'b0}}, s1_mag_r};
  end

  // Stage 2: update the window and register the outputs; the final sample of
  // an utterance is emitted with its own average and then all state restarts.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      ovalid <= 1'b0;
      olast  <= 1'b0;
      oidx   <= {IDX_W{1'b0}};
      odata  <= 16'd0;
      sum_r  <= {SUM_W{1'b0}};
      idx_r  <= {IDX_W{1'b0}};
      ptr_r  <= {LOG2_WIN{1'b0}};
      for (int i = 0; i < WIN; i++) begin
        hist_r[i] <= 15'd0;
      end
    end else if (s1_valid_r) begin
      ovalid <= 1'b1;
      olast  <= s1_last_r;
      oidx   <= idx_r;
      odata  <= {1'b0, sum_next_s[SUM_W-1:LOG2_WIN]};
      if (s1_last_r) begin
        sum_r <= {SUM_W{1'b0}};
        idx_r <= {IDX_W{1'b0}};
        ptr_r <= {LOG2_WIN{1'b0}};
        for (int i = 0; i < WIN; i++) begin
          hist_r[i] <= 15'd0;
        end
      end else begin
        sum_r         <= sum_next_s;
        idx_r         <= idx_r + IDX_W'(1);
        ptr_r         <= ptr_r + LOG2_WIN'(1);
        hist_r[ptr_r] <= s1_mag_r;
      end
    end else begin
      ovalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sample_envelope.sv
// Testbench for sample_envelope: directed vector table, hand-written corner
// sequences (async reset mid-flight, DC decay when enabled) and random stimulus
// checked against a queue-based moving-average model.
module tb_sample_envelope;

  localparam int LOG2_WIN = 4;
  localparam int IDX_W    = 32;
  localparam int DC_SHIFT = 8;
  localparam int WIN      = 1 << LOG2_WIN;
`ifdef SAMPLE_ENVELOPE_DC_REMOVE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic             iclk = 1'b0;
  logic             irst;
  logic             ivalid;
  logic             ilast;
  logic [15:0]      isample;
  logic             ovalid;
  logic             olast;
  logic [IDX_W-1:0] oidx;
  logic [15:0]      odata;

  sample_envelope #(.LOG2_WIN(LOG2_WIN), .IDX_W(IDX_W), .DC_SHIFT(DC_SHIFT)) dut (
    .iclk(iclk), .irst(irst), .ivalid(ivalid), .ilast(ilast), .isample(isample),
    .ovalid(ovalid), .olast(olast), .oidx(oidx), .odata(odata)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    int due;
    int d;
    int i;
    bit l;
  } exp_t;

  typedef struct {
    bit          rst;
    bit          v;
    bit          l;
    logic [15:0] s;
    int          ed;
    int          ei;
    bit          el;
  } vec_t;

  exp_t expq[$];
  vec_t tbl[$];
  int   ecount = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   last_od = 0;
  int   max_od  = 0;

  // Reference model state: magnitudes of the current utterance window.
  int m_hist[$];
  int m_idx = 0;
  int m_dc  = 0;

  always @(posedge iclk) ecount <= ecount + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Output monitor: each cycle either the due expectation or silence.
  always @(negedge iclk) begin
    exp_t e;
    if (expq.size() > 0 && expq[0].due == ecount) begin
      e = expq.pop_front();
      chk("ovalid", 64'(ovalid), 64'd1);
      chk("odata", 64'(odata), 64'(e.d));
      chk("oidx", 64'(oidx), 64'(e.i));
      chk("olast", 64'(olast), 64'(e.l));
      chk("odata_msb", 64'(odata[15]), 64'd0);
      last_od = int'(odata);
      if (int'(odata) > max_od) max_od = int'(odata);
    end else begin
      chk("ovalid_idle", 64'(ovalid), 64'd0);
    end
  end

  function automatic void model_reset();
    m_hist.delete();
    m_idx = 0;
    m_dc  = 0;
  endfunction

  // Envelope of one accepted sample, straight from the averaging rules.
  task automatic model_push(input logic [15:0] s, input bit last, output int d, output int ix);
    int x, diff, mag, sum;
    x = int'($signed(s));
    diff = 0;
`ifdef SAMPLE_ENVELOPE_DC_REMOVE_EN
    diff = x - m_dc;
    x = (diff > 32767) ? 32767 : ((diff < -32768) ? -32768 : diff);
    m_dc = last ? 0 : m_dc + (diff >>> DC_SHIFT);
`endif
    mag = (x < 0) ? -x : x;
    if (mag > 32767) mag = 32767;
    m_hist.push_back(mag);
    if (m_hist.size() > WIN) void'(m_hist.pop_front());
    sum = 0;
    foreach (m_hist[k]) sum += m_hist[k];
    d  = sum / WIN;
    ix = m_idx;
    if (last) begin
      m_hist.delete();
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  task automatic drive(input bit v, input bit l, input logic [15:0] s,
                       input int ed, input int ei, input bit el);
    exp_t e;
    @(negedge iclk);
    ivalid  = v;
    ilast   = l;
    isample = s;
    if (v) begin
      e.due = ecount + LAT;
      e.d = ed;
      e.i = ei;
      e.l = el;
      expq.push_back(e);
    end
  endtask

  task automatic drive_model(input bit v, input bit l, input logic [15:0] s);
    int d, ix;
    d = 0;
    ix = 0;
    if (v) model_push(s, l, d, ix);
    drive(v, l, s, d, ix, v & l);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 16'd0, 0, 0, 1'b0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (expq.size() > 0 && k < 40) begin
      idle(1);
      k++;
    end
    chk("drain_timeout", 64'(expq.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge iclk);
    irst   = 1'b1;
    ivalid = 1'b0;
    ilast  = 1'b0;
    expq.delete();
    model_reset();
    @(negedge iclk);
    @(negedge iclk);
    chk("rst_ovalid", 64'(ovalid), 64'd0);
    chk("rst_olast", 64'(olast), 64'd0);
    chk("rst_oidx", 64'(oidx), 64'd0);
    chk("rst_odata", 64'(odata), 64'd0);
    irst = 1'b0;
  endtask

  task automatic add(input bit rst, input bit v, input bit l, input logic [15:0] s,
                     input int ed, input int ei, input bit el);
    vec_t r;
    r.rst = rst; r.v = v; r.l = l; r.s = s; r.ed = ed; r.ei = ei; r.el = el;
    tbl.push_back(r);
  endtask

  initial begin
    int d, ix, gap_start;
    logic [15:0] s;
    irst    = 1'b1;
    ivalid  = 1'b0;
    ilast   = 1'b0;
    isample = 16'd0;

`ifndef SAMPLE_ENVELOPE_DC_REMOVE_EN
    // 16 x +1000, last on the 16th.
    for (int k = 1; k <= 16; k++) add(k == 1, 1'b1, k == 16, 16'd1000, (k * 1000) / 16, k - 1, k == 16);
    // 20 x -1000: ramp then hold at 1000 across the buffer wrap.
    for (int k = 1; k <= 20; k++) add(k == 1, 1'b1, 1'b0, 16'(-1000), ((k > 16 ? 16 : k) * 1000) / 16, k - 1, 1'b0);
    // 16 x -32768: magnitude saturates.
    for (int k = 1; k <= 16; k++) add(k == 1, 1'b1, 1'b0, 16'h8000, (k * 32767) / 16, k - 1, 1'b0);
    // Utterance of 3 x +1600 then +160 with no gap.
    add(1'b1, 1'b1, 1'b0, 16'd1600, 100, 0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'd1600, 200, 1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 16'd1600, 300, 2, 1'b1);
    add(1'b0, 1'b1, 1'b0, 16'd160, 10, 0, 1'b0);
    // ivalid toggling with ilast only on invalid cycles.
    add(1'b1, 1'b1, 1'b0, 16'd800, 50, 0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 16'd800, 0, 0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'd800, 100, 1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 16'd800, 0, 0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'd800, 150, 2, 1'b0);

    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].rst) begin
        drain();
        do_reset();
      end
      drive(tbl[k].v, tbl[k].l, tbl[k].s, tbl[k].ed, tbl[k].ei, tbl[k].el);
    end
    drain();
`else
    // Constant +4000 with DC removal: envelope peaks then decays.
    do_reset();
    max_od = 0;
    for (int k = 0; k < 1500; k++) drive_model(1'b1, 1'b0, 16'd4000);
    drain();
    chk("dc_decay", 64'(last_od < max_od / 4), 64'd1);
`endif

    // Async reset mid-cycle with two samples in flight.
    do_reset();
    drive_model(1'b1, 1'b0, 16'd3200);
    drive_model(1'b1, 1'b0, 16'd3200);
    @(posedge iclk);
    #2;
    irst = 1'b1;
    expq.delete();
    model_reset();
    #1;
    chk("async_rst_ovalid", 64'(ovalid), 64'd0);
    @(negedge iclk);
    ivalid = 1'b0;
    @(negedge iclk);
    irst = 1'b0;
    drive_model(1'b1, 1'b0, 16'd4800);
    gap_start = ecount;
    drain();
    chk("post_rst_latency", 64'(ecount - gap_start >= LAT), 64'd1);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      case ($urandom % 4)
        0: s = 16'($urandom);
        1: s = 16'($urandom_range(400)) - 16'd200;
        2: s = ($urandom % 2) ? 16'h8000 : 16'h7fff;
        default: s = 16'($urandom_range(20000));
      endcase
      drive_model(($urandom % 4) != 0, ($urandom % 23) == 0, s);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
